// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display prefetch owns one fixed slot per pixel word,
// the host uses every other cycle through a valid/ready handshake.
module vga_fb_arbiter #(
    parameter int unsigned H_DISPLAY       = 640,
    parameter int unsigned H_TOTAL         = 800,
    parameter int unsigned V_DISPLAY       = 480,
    parameter int unsigned V_TOTAL         = 525,
    parameter int unsigned PIX_W           = 4,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned ADDR_W          = 17,
    parameter bit          HOST_BLANK_ONLY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    input  logic              display_on,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [PIX_W-1:0]  pixel_o,
    output logic              pixel_de
);

    localparam int unsigned PPW  = DATA_W / PIX_W;
    localparam int unsigned PH_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int unsigned WPL  = H_DISPLAY / PPW;

    logic [PH_W-1:0]   phase;
    logic [10:0]       n_pos;
    logic [9:0]        nline;
    logic [9:0]        nline_inc;
    logic              fetch_slot;
    logic [ADDR_W-1:0] fetch_addr;

    logic              rd_pend_q, rd_pend_d;
    logic              rd_host_q, rd_host_d;   // read owner: 1 = host, 0 = display
    logic [DATA_W-1:0] next_word_q, next_word_d;
    logic [DATA_W-1:0] cur_word_q, cur_word_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    logic              pixel_de_q, pixel_de_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0] pix_sh;

    // Locate the next pixel group and decide whether this cycle is a prefetch slot.
    always_comb begin
        phase     = hpos[PH_W-1:0];
        n_pos     = {1'b0, hpos} + 11'(PPW);
        nline     = vpos;
        nline_inc = vpos + 10'd1;
        if (n_pos >= 11'(H_TOTAL)) begin
            n_pos = n_pos - 11'(H_TOTAL);
            nline = (nline_inc == 10'(V_TOTAL)) ? '0 : nline_inc;
        end
        fetch_slot = (phase == '0) && (n_pos < 11'(H_DISPLAY)) && (nline < 10'(V_DISPLAY));
        fetch_addr = ADDR_W'(nline) * ADDR_W'(WPL) + ADDR_W'(n_pos >> PH_W);
    end

    // Drive the RAM port: fixed display slot, otherwise pass the host through.
    always_comb begin
        host_ready = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        if (!reset) begin
            if (fetch_slot) begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr;
            end else begin
                host_ready = HOST_BLANK_ONLY ? !display_on : 1'b1;
                mem_en     = host_valid && host_ready;
                mem_we     = host_we;
            end
        end
    end

    // Route read data to its owner and build the pixel stream.
    always_comb begin
        rd_pend_d     = mem_en && !mem_we;
        rd_host_d     = !fetch_slot;
        host_rvalid_d = rd_pend_q && rd_host_q;
        host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
        next_word_d   = next_word_q;
        if (rd_pend_q && !rd_host_q && (phase == PH_W'(1))) begin
            next_word_d = mem_rdata;
        end
        cur_word_d = (phase == '0) ? next_word_q : cur_word_q;
        pix_sh     = cur_word_q >> (phase * PIX_W);
        pixel_d    = '0;
        if (display_on) begin
            pixel_d = (phase == '0) ? next_word_q[PIX_W-1:0] : pix_sh[PIX_W-1:0];
        end
        pixel_de_d = display_on;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q     <= 1'b0;
            rd_host_q     <= 1'b0;
            next_word_q   <= '0;
            cur_word_q    <= '0;
            pixel_q       <= '0;
            pixel_de_q    <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            rd_pend_q     <= rd_pend_d;
            rd_host_q     <= rd_host_d;
            next_word_q   <= next_word_d;
            cur_word_q    <= cur_word_d;
            pixel_q       <= pixel_d;
            pixel_de_q    <= pixel_de_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign pixel_o     = pixel_q;
    assign pixel_de    = pixel_de_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: one instance per HOST_BLANK_ONLY setting,
// each with its own behavioural single-port RAM.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = '0;
    logic        display_on = 1'b0;
    logic        host_valid = 1'b0;
    logic        host_we = 1'b0;
    logic [16:0] host_addr = '0;
    logic [15:0] host_wdata = '0;

    logic        host_ready, host_rvalid, mem_en, mem_we, pixel_de;
    logic [15:0] host_rdata, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [16:0] mem_addr;
    logic [3:0]  pixel_o;

    logic        b_host_ready, b_host_rvalid, b_mem_en, b_mem_we, b_pixel_de;
    logic [15:0] b_host_rdata, b_mem_wdata;
    logic [15:0] b_mem_rdata = '0;
    logic [16:0] b_mem_addr;
    logic [3:0]  b_pixel_o;

    logic [15:0] ram   [0:255];
    logic [15:0] ram_b [0:255];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.HOST_BLANK_ONLY(1'b0)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pixel_o(pixel_o), .pixel_de(pixel_de)
    );

    vga_fb_arbiter #(.HOST_BLANK_ONLY(1'b1)) dut_b (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .host_valid(host_valid), .host_ready(b_host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(b_host_rdata),
        .host_rvalid(b_host_rvalid), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .pixel_o(b_pixel_o), .pixel_de(b_pixel_de)
    );

    // Synchronous single-port RAMs, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
        if (b_mem_en) begin
            if (b_mem_we) ram_b[b_mem_addr[7:0]] <= b_mem_wdata;
            else          b_mem_rdata <= ram_b[b_mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int v, input int h, input logic de);
        vpos       = 10'(v);
        hpos       = 10'(h);
        display_on = de;
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (pixel_de !== 1'b0) begin n_err++; $display("FAIL rst_pixel_de got %b want 0", pixel_de); end
        n_cmp++; if (pixel_o !== 4'h0) begin n_err++; $display("FAIL rst_pixel_o got %h want 0", pixel_o); end
        n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got %b want 0", host_rvalid); end
        n_cmp++; if (host_rdata !== 16'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", host_rdata); end
        tick();
        reset = 1'b0;
        host_valid = 1'b1;
        host_we = 1'b0;
        host_addr = 17'd0;
        set_pos(10, 1, 1'b1);
        n_cmp++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL run_ready got %b want 1", host_ready); end
        n_cmp++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL run_mem_en got %b want 1", mem_en); end
        tick();
        n_cmp++; if (pixel_de !== 1'b1) begin n_err++; $display("FAIL run_pixel_de got %b want 1", pixel_de); end
        // Assert reset between clock edges: everything must drop at once.
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL async_mem_en got %b want 0", mem_en); end
        n_cmp++; if (host_ready !== 1'b0) begin n_err++; $display("FAIL async_ready got %b want 0", host_ready); end
        n_cmp++; if (pixel_de !== 1'b0) begin n_err++; $display("FAIL async_pixel_de got %b want 0", pixel_de); end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL resume_ready got %b want 1", host_ready); end
        tick();
        host_valid = 1'b0;
    endtask

    task automatic test_fetch_addr();
        int vec [3][3] = '{'{524, 796, 0}, '{0, 4, 2}, '{0, 796, 160}};
        for (int i = 0; i < 3; i++) begin
            set_pos(vec[i][0], vec[i][1], 1'b0);
            n_cmp++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL fetch_en[%0d] got %b want 1", i, mem_en); end
            n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_we[%0d] got %b want 0", i, mem_we); end
            n_cmp++; if (host_ready !== 1'b0) begin n_err++; $display("FAIL fetch_ready[%0d] got %b want 0", i, host_ready); end
            n_cmp++; if (mem_addr !== 17'(vec[i][2])) begin n_err++; $display("FAIL fetch_addr[%0d] got %0d want %0d", i, mem_addr, vec[i][2]); end
        end
        tick();
    endtask

    task automatic test_no_fetch();
        int vec [2][2] = '{'{10, 636}, '{479, 796}};
        for (int i = 0; i < 2; i++) begin
            set_pos(vec[i][0], vec[i][1], 1'b0);
            n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL nofetch_en[%0d] got %b want 0", i, mem_en); end
            n_cmp++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL nofetch_ready[%0d] got %b want 1", i, host_ready); end
        end
        set_pos(10, 640, 1'b0);
        tick();
        n_cmp++; if (pixel_de !== 1'b0) begin n_err++; $display("FAIL blank_de got %b want 0", pixel_de); end
        n_cmp++; if (pixel_o !== 4'h0) begin n_err++; $display("FAIL blank_pix got %h want 0", pixel_o); end
    endtask

    task automatic test_pixels();
        ram[0] = 16'h4321;
        ram[1] = 16'h8765;
        for (int h = 796; h < 800; h++) begin
            set_pos(524, h, 1'b0);
            tick();
        end
        for (int h = 0; h < 8; h++) begin
            set_pos(0, h, 1'b1);
            tick();
            n_cmp++; if (pixel_o !== 4'(h + 1)) begin n_err++; $display("FAIL pix[%0d] got %h want %h", h, pixel_o, 4'(h + 1)); end
            n_cmp++; if (pixel_de !== 1'b1) begin n_err++; $display("FAIL pix_de[%0d] got %b want 1", h, pixel_de); end
            n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL pix_rvalid[%0d] got %b want 0", h, host_rvalid); end
        end
    endtask

    task automatic test_host_stall();
        ram[5] = 16'hA5A5;
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_addr  = 17'd5;
        set_pos(0, 8, 1'b1);
        n_cmp++; if (host_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b want 0", host_ready); end
        n_cmp++; if (mem_addr !== 17'd3) begin n_err++; $display("FAIL stall_fetch_addr got %0d want 3", mem_addr); end
        tick();
        set_pos(0, 9, 1'b1);
        n_cmp++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL accept_ready got %b want 1", host_ready); end
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL accept_en got %b%b want 10", mem_en, mem_we); end
        n_cmp++; if (mem_addr !== 17'd5) begin n_err++; $display("FAIL accept_addr got %0d want 5", mem_addr); end
        tick();
        host_valid = 1'b0;
        set_pos(0, 10, 1'b1);
        n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL rvalid_early got %b want 0", host_rvalid); end
        tick();
        n_cmp++; if (host_rvalid !== 1'b1) begin n_err++; $display("FAIL rvalid got %b want 1", host_rvalid); end
        n_cmp++; if (host_rdata !== 16'hA5A5) begin n_err++; $display("FAIL rdata got %h want a5a5", host_rdata); end
        set_pos(0, 11, 1'b1);
        tick();
        n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL rvalid_pulse got %b want 0", host_rvalid); end
    endtask

    task automatic test_blank_only();
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 17'd9;
        host_wdata = 16'hBEEF;
        set_pos(10, 1, 1'b1);
        n_cmp++; if (b_host_ready !== 1'b0) begin n_err++; $display("FAIL bo_vis_ready got %b want 0", b_host_ready); end
        n_cmp++; if (b_mem_en !== 1'b0) begin n_err++; $display("FAIL bo_vis_en got %b want 0", b_mem_en); end
        tick();
        set_pos(10, 640, 1'b0);
        n_cmp++; if (b_host_ready !== 1'b1) begin n_err++; $display("FAIL bo_blank_ready got %b want 1", b_host_ready); end
        n_cmp++; if (b_mem_en !== 1'b1 || b_mem_we !== 1'b1) begin n_err++; $display("FAIL bo_wr_en got %b%b want 11", b_mem_en, b_mem_we); end
        n_cmp++; if (b_mem_addr !== 17'd9) begin n_err++; $display("FAIL bo_wr_addr got %0d want 9", b_mem_addr); end
        tick();
        host_we = 1'b0;
        set_pos(10, 641, 1'b0);
        n_cmp++; if (b_host_ready !== 1'b1) begin n_err++; $display("FAIL bo_rd_ready got %b want 1", b_host_ready); end
        tick();
        host_valid = 1'b0;
        set_pos(10, 642, 1'b0);
        tick();
        n_cmp++; if (b_host_rvalid !== 1'b1) begin n_err++; $display("FAIL bo_rvalid got %b want 1", b_host_rvalid); end
        n_cmp++; if (b_host_rdata !== 16'hBEEF) begin n_err++; $display("FAIL bo_rdata got %h want beef", b_host_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   = '0;
            ram_b[i] = '0;
        end
        #2;
        test_reset();
        test_fetch_addr();
        test_no_fetch();
        test_pixels();
        test_host_stall();
        test_blank_only();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
